// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard for the issue stage.
// Two combinational read ports, one writeback port, optional writeback bypass.
module regfile_sb #(
  parameter int XLEN   = 4,
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            wb_live;
  logic            accept;
  logic            set_new;
  logic            clr_old;
  logic [AW:0]     busy_cnt_nxt;

  // Address 0 is hardwired zero and never busy, so writes to it are dropped here.
  assign wb_live = wb_we && (wb_addr != '0);

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_addr != '0) begin
      if ((BYPASS != 0) && wb_we && (wb_addr == rs1_addr)) begin
        rs1_data = wb_data;
      end else begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_addr != '0) begin
      if ((BYPASS != 0) && wb_we && (wb_addr == rs2_addr)) begin
        rs2_data = wb_data;
      end else begin
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
      end
    end
  end

  // A same-cycle writeback to the reserved register frees it for the new reservation.
  assign iss_ready = (iss_rd == '0) || !busy[iss_rd] || (wb_we && (wb_addr == iss_rd));
  assign accept    = iss_valid && iss_ready;
  assign set_new   = accept && (iss_rd != '0) && !busy[iss_rd];
  assign clr_old   = wb_live && busy[wb_addr] && !(accept && (iss_rd == wb_addr));

  always_comb begin
    busy_cnt_nxt = busy_cnt;
    if (set_new && !clr_old) begin
      busy_cnt_nxt = busy_cnt + (AW+1)'(1);
    end else if (clr_old && !set_new) begin
      busy_cnt_nxt = busy_cnt - (AW+1)'(1);
    end
  end

  // State update: a reservation issued on the same edge overrides the writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wb_live) begin
        regs[wb_addr] <= wb_data;
        busy[wb_addr] <= 1'b0;
      end
      if (accept && (iss_rd != '0)) begin
        busy[iss_rd] <= 1'b1;
      end
      busy_cnt <= busy_cnt_nxt;
    end
  end

endmodule
